// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: combinational lookup, EX-driven update.
// Optional BTB_COUNTER_EN adds 2-bit saturating direction counters.
module btb_table #(
    parameter int IDX_BITS = 4,
    parameter int PC_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_W-1:0]     pc_in,
    output logic                hit,
    output logic [PC_W-1:0]     target,
    output logic                taken_pred,
    input  logic                upd_en,
    input  logic [PC_W-1:0]     upd_pc,
    input  logic [PC_W-1:0]     upd_target,
    input  logic                upd_taken,
    input  logic                flush_all,
    output logic [IDX_BITS:0]   valid_count
);

    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam int TAG_W   = PC_W - IDX_BITS - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];
`ifdef BTB_COUNTER_EN
    logic [1:0]         ctr_q [ENTRIES];
`endif
    logic [IDX_BITS:0]  count_q;

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_W-1:0]    rd_tag;
    logic [TAG_W-1:0]    wr_tag;
    logic                rd_hit;
    logic                wr_match;
    logic                do_fill;
`ifndef BTB_COUNTER_EN
    logic                do_inval;
`endif
    logic                unused_bits;

    assign rd_idx = pc_in[IDX_BITS+1:2];
    assign rd_tag = pc_in[PC_W-1:IDX_BITS+2];
    assign wr_idx = upd_pc[IDX_BITS+1:2];
    assign wr_tag = upd_pc[PC_W-1:IDX_BITS+2];

    // Byte offset bits never participate in indexing or tagging.
    assign unused_bits = ^{pc_in[1:0], upd_pc[1:0]};

    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign hit    = rd_hit;
    assign target = rd_hit ? tgt_q[rd_idx] : '0;
`ifdef BTB_COUNTER_EN
    assign taken_pred = rd_hit && ctr_q[rd_idx][1];
`else
    assign taken_pred = rd_hit;
`endif

    assign wr_match = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    // Allocation into an empty slot is the only event that grows the count.
    assign do_fill  = upd_en && !wr_match && upd_taken && !valid_q[wr_idx];
`ifndef BTB_COUNTER_EN
    assign do_inval = upd_en && wr_match && !upd_taken;
`endif

    // Table state: reset beats flush beats resolution update.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
`ifdef BTB_COUNTER_EN
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
`endif
        end else if (flush_all) begin
            valid_q <= '0;
        end else if (upd_en) begin
            if (wr_match) begin
                if (upd_taken) begin
                    tgt_q[wr_idx] <= upd_target;
`ifdef BTB_COUNTER_EN
                    if (ctr_q[wr_idx] != 2'b11) begin
                        ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'b01;
                    end
`endif
                end else begin
`ifdef BTB_COUNTER_EN
                    if (ctr_q[wr_idx] != 2'b00) begin
                        ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'b01;
                    end
`else
                    valid_q[wr_idx] <= 1'b0;
`endif
                end
            end else if (upd_taken) begin
                valid_q[wr_idx] <= 1'b1;
                tag_q[wr_idx]   <= wr_tag;
                tgt_q[wr_idx]   <= upd_target;
`ifdef BTB_COUNTER_EN
                ctr_q[wr_idx]   <= 2'b10;
`endif
            end
        end
    end

    // Occupancy counter tracking valid bits, clamped at both ends.
    always_ff @(posedge clk) begin
        if (rst || flush_all) begin
            count_q <= '0;
        end else if (do_fill) begin
            if (count_q != (IDX_BITS+1)'(ENTRIES)) begin
                count_q <= count_q + 1'b1;
            end
`ifndef BTB_COUNTER_EN
        end else if (do_inval) begin
            if (count_q != '0) begin
                count_q <= count_q - 1'b1;
            end
`endif
        end
    end

    assign valid_count = count_q;

endmodule

// File: tb/tb_btb_table.sv
// Scoreboard bench for btb_table: directed plan plus random traffic
// checked against an array model keyed by word-aligned PC line.
module tb_btb_table;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0;
    logic        hit;
    logic [31:0] target;
    logic        taken_pred;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;
    logic        flush_all = 1'b0;
    logic [4:0]  valid_count;

    btb_table #(.IDX_BITS(4), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .hit(hit),
        .target(target), .taken_pred(taken_pred),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .flush_all(flush_all),
        .valid_count(valid_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic [31:0] tgt;
        logic        tk;
        logic [4:0]  cnt;
        int          id;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int step_id = 0;
    bit known = 0;

    bit          m_valid [16];
    logic [29:0] m_line  [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];

    function automatic int idx_of(input logic [31:0] p);
        return int'(p[31:2]) % 16;
    endfunction

    function automatic bit model_hit(input logic [31:0] p);
        int i;
        i = idx_of(p);
        return m_valid[i] && (m_line[i] == p[31:2]);
    endfunction

    function automatic exp_t predict(input logic [31:0] p);
        exp_t e;
        int n;
        int i;
        i = idx_of(p);
        e.hit = model_hit(p);
        e.tgt = e.hit ? m_tgt[i] : 32'h0;
`ifdef BTB_COUNTER_EN
        e.tk = e.hit && (m_ctr[i] >= 2);
`else
        e.tk = e.hit;
`endif
        n = 0;
        for (int k = 0; k < 16; k++) n += int'(m_valid[k]);
        e.cnt = 5'(n);
        e.id = step_id;
        return e;
    endfunction

    task automatic apply(input logic r, input logic f, input logic e,
                         input logic [31:0] up, input logic [31:0] ut,
                         input logic tk);
        int i;
        bit h;
        if (r) begin
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 0;
                m_ctr[k] = 1;
            end
        end else if (f) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 0;
        end else if (e) begin
            i = idx_of(up);
            h = model_hit(up);
            if (h && tk) begin
                m_tgt[i] = ut;
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            end else if (h) begin
`ifdef BTB_COUNTER_EN
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
`else
                m_valid[i] = 0;
`endif
            end else if (tk) begin
                m_valid[i] = 1;
                m_line[i] = up[31:2];
                m_tgt[i] = ut;
                m_ctr[i] = 2;
            end
        end
    endtask

    task automatic step(input logic r, input logic f, input logic e,
                        input logic [31:0] p, input logic [31:0] up,
                        input logic [31:0] ut, input logic tk);
        @(posedge clk);
        #1;
        rst = r;
        flush_all = f;
        upd_en = e;
        pc_in = p;
        upd_pc = up;
        upd_target = ut;
        upd_taken = tk;
        step_id++;
        if (known) q.push_back(predict(p));
        apply(r, f, e, up, ut, tk);
        if (r) known = 1;
    endtask

    task automatic look(input logic [31:0] p);
        step(0, 0, 0, p, 32'h0, 32'h0, 0);
    endtask

    task automatic upd(input logic [31:0] up, input logic [31:0] ut,
                       input logic tk);
        step(0, 0, 1, up, up, ut, tk);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 32'h0040_0010, 32'h0, 32'h0, 0);
    endtask

    function automatic logic [31:0] mkpc();
        return 32'h0040_0000 + (32'($urandom_range(0, 3)) << 6)
             + (32'($urandom_range(0, 15)) << 2)
             + 32'($urandom_range(0, 3));
    endfunction

    // Monitor: compare DUT outputs mid-cycle against queued predictions.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks += 4;
                if (hit !== e.hit) begin
                    errors++;
                    $display("FAIL hit step %0d: got %b want %b",
                             e.id, hit, e.hit);
                end
                if (target !== e.tgt) begin
                    errors++;
                    $display("FAIL target step %0d: got %h want %h",
                             e.id, target, e.tgt);
                end
                if (taken_pred !== e.tk) begin
                    errors++;
                    $display("FAIL taken_pred step %0d: got %b want %b",
                             e.id, taken_pred, e.tk);
                end
                if (valid_count !== e.cnt) begin
                    errors++;
                    $display("FAIL valid_count step %0d: got %0d want %0d",
                             e.id, valid_count, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int r;

        do_reset();
        look(32'h0040_0010);
        upd(32'h0040_0010, 32'h0040_0100, 1);
        look(32'h0040_0010);
        upd(32'h0040_0010, 32'h0040_0200, 0);
        look(32'h0040_0010);
        upd(32'h0040_0010, 32'h0040_0200, 0);
        look(32'h0040_0010);
        upd(32'h0040_0010, 32'h0040_0300, 1);
        look(32'h0040_0010);
        upd(32'h0040_0010, 32'h0040_0400, 1);
        look(32'h0040_0010);

        do_reset();
        upd(32'h0040_0010, 32'h0040_0100, 1);
        upd(32'h0040_1010, 32'h0040_0500, 1);
        look(32'h0040_0010);
        look(32'h0040_1010);
        upd(32'h0040_2010, 32'h0040_0600, 0);
        look(32'h0040_1010);
        look(32'h0040_2010);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            upd(32'h0040_0000 + 32'(i * 4), 32'h0050_0000 + 32'(i), 1);
        end
        look(32'h0040_0000);
        step(0, 1, 1, 32'h0040_3000, 32'h0040_3000, 32'h0060_0000, 1);
        for (int i = 0; i < 16; i++) look(32'h0040_0000 + 32'(i * 4));
        look(32'h0040_3000);

        do_reset();
        for (int i = 0; i < 6; i++) upd(32'h0040_0024, 32'h0070_0000, 1);
        look(32'h0040_0024);
        upd(32'h0040_0024, 32'h0070_0000, 0);
        look(32'h0040_0027);

        step(1, 0, 1, 32'h0040_0030, 32'h0040_0030, 32'h0080_0000, 1);
        look(32'h0040_0030);

        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            a = mkpc();
            b = ($urandom_range(0, 1) == 1) ? a : mkpc();
            step(r < 1, (r >= 1) && (r < 3), 1'($urandom_range(0, 1)),
                 b, a, $urandom, 1'($urandom_range(0, 1)));
        end
        step(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_table.md
Name: btb_table

Overview:
- Direct-mapped branch target buffer for the parallel-fetch MIPS pipeline.
- Looks up the fetch PC combinationally and produces the raw hit, predicted target and direction.
- Raw hit feeds the downstream hit-qualification stage, which masks it with the flush/stall condition before PC select.
- Table state is updated synchronously from branch resolution in EX.

Parameters:
- IDX_BITS, 4, index width; ENTRIES = 2**IDX_BITS (16).
- PC_W, 32, PC and target width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- pc_in  input  PC_W  fetch PC to look up.
- hit  output  1  raw hit: entry valid and tag match.
- target  output  PC_W  predicted target; 0 when hit=0.
- taken_pred  output  1  predicted taken; 0 when hit=0.
- upd_en  input  1  resolution update strobe, one per resolved branch.
- upd_pc  input  PC_W  PC of the resolved branch.
- upd_target  input  PC_W  resolved branch target.
- upd_taken  input  1  resolved direction.
- flush_all  input  1  invalidate the whole table.
- valid_count  output  IDX_BITS+1  number of valid entries.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Address split:
  - index = pc[IDX_BITS+1:2].
  - tag = pc[PC_W-1:IDX_BITS+2].
  - pc[1:0] are ignored.
- Per entry: valid bit, tag, target, 2-bit counter.
- Lookup (combinational, 0-cycle latency):
  - hit = valid[idx] && tag[idx]==tag(pc_in).
  - target = hit ? tgt[idx] : 0.
  - taken_pred = hit && ctr[idx][1].
- Update on rising clk edge; priority rst > flush_all > upd_en.
- rst:
  - All valid bits cleared, all counters set to 2'b01.
  - valid_count=0; hit, taken_pred and target read 0 from the next cycle.
  - rst asserted mid-update: the update is discarded.
- flush_all:
  - All valid bits cleared, valid_count=0.
  - Counters and targets are untouched; an upd_en in the same cycle is dropped.
- upd_en with a match (valid and tag equal at upd index):
  - upd_taken=1: counter increments, saturating at 3; target is overwritten with upd_target.
  - upd_taken=0: counter decrements, saturating at 0; target is kept.
- upd_en with a miss:
  - upd_taken=1: allocate. valid=1, tag and target written, counter=2'b10 (weakly taken). Replaces any valid conflicting entry.
  - upd_taken=0: no change.
- valid_count:
  - +1 on allocation into an invalid slot.
  - Unchanged on replacement of a valid slot.
  - -1 on invalidation (optional feature off).
  - Never exceeds ENTRIES and never underflows.
- Read-during-write: a lookup of the index being updated in the same cycle returns the pre-update contents. The new contents are visible the cycle after the edge.
- No handshake: upd_en is a single-cycle strobe, and every strobe is consumed.

Optional Feature:
- Macro BTB_COUNTER_EN.
- Defined: 2-bit saturating counters as described; taken_pred = hit && ctr[1].
- Undefined:
  - Counters are not implemented; taken_pred = hit.
  - A matching update with upd_taken=0 clears that entry's valid bit, and valid_count decrements.
  - A matching update with upd_taken=1 overwrites the target.
  - Miss behaviour is unchanged.

Test Plan:
- Reset then lookup: rst=1 one cycle, pc_in=0x00400010 -> hit=0, target=0, taken_pred=0, valid_count=0.
- Allocate: upd_en, upd_pc=0x00400010, upd_target=0x00400100, upd_taken=1; next cycle pc_in=0x00400010 -> hit=1, target=0x00400100, taken_pred=1, valid_count=1. Same-cycle lookup during the write -> hit=0.
- Counter hysteresis (COUNTER_EN): starting from the allocated entry (ctr=2), two not-taken updates -> ctr=0, taken_pred=0, hit=1. One taken update -> ctr=1, taken_pred=0. Second taken update -> ctr=2, taken_pred=1. Without the macro: the first not-taken update -> hit=0, valid_count=0.
- Aliasing: allocate 0x00400010, then allocate 0x00401010 (same index 4) -> lookup 0x00400010 hit=0, 0x00401010 hit=1, valid_count stays 1. Not-taken miss update on 0x00402010 -> no change.
- Fill and flush: allocate all 16 indices -> valid_count=16. Assert flush_all together with upd_en -> valid_count=0, all lookups miss, and the update is dropped.
- Saturation: five taken updates on one entry -> ctr stays 3 and no wrap. After reset, ctr reads 2'b01 on the next allocation path (allocation writes 2'b10).
